// File: rtl/rcn_pkg.sv
// Shared rcn transaction constants and helpers.
package rcn_pkg;

    localparam int unsigned RCN_W      = 69;
    localparam int unsigned RCN_VALID  = 68;
    localparam int unsigned RCN_DATA_W = 68;

    // Port index width; fixed at 3 bits for all supported port counts (2..8).
    function automatic int unsigned port_idx_w(int unsigned ports);
        return (ports <= 8) ? 3 : $clog2(ports);
    endfunction

endpackage

// File: rtl/rcn_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rcn_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan offsets from farthest to nearest so the nearest match overrides.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        if (en) begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                for (int i = 0; i < int'(N); i++) begin
                    if (req[i] && (i == (int'(ptr) + k) % int'(N))) begin
                        gnt    = '0;
                        gnt[i] = 1'b1;
                        idx    = IW'(i);
                        any    = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rcn_fifo_push_arb.sv
// Round-robin arbiter sharing one rcn async FIFO push port among PORTS requesters,
// each with a one-entry holding register.
module rcn_fifo_push_arb
    import rcn_pkg::*;
#(
    parameter int unsigned PORTS = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [PORTS*RCN_W-1:0]   req_rcn,
    output logic [PORTS-1:0]         req_busy,
    output logic [RCN_W-1:0]         fifo_rcn,
    output logic                     fifo_push,
    input  logic                     fifo_full,
    output logic [2:0]               gnt_idx
);

    localparam int unsigned IdxW = port_idx_w(PORTS);
    localparam logic [IdxW-1:0] LastPort = IdxW'(PORTS - 1);

    logic [PORTS-1:0]      req_v;
    logic [PORTS-1:0]      hold_v;
    logic [PORTS-1:0]      gnt;
    logic [PORTS-1:0]      cap;
    logic [RCN_DATA_W-1:0] hold_d [PORTS];
    logic [IdxW-1:0]       rr_ptr;
    logic [IdxW-1:0]       rr_next;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_any;

    always_comb begin
        req_v = '0;
        for (int i = 0; i < int'(PORTS); i++) begin
            req_v[i] = req_rcn[RCN_W*i + RCN_VALID];
        end
    end

    rcn_rr_pick #(
        .N  (PORTS),
        .IW (IdxW)
    ) u_pick (
        .req (hold_v),
        .ptr (rr_ptr),
        .en  (~fifo_full),
        .gnt (gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A holder being drained this cycle is free to recapture at the same edge.
    assign req_busy  = hold_v & ~gnt;
    assign cap       = req_v & ~req_busy;
    assign fifo_push = pick_any;
    assign gnt_idx   = pick_idx;
    assign rr_next   = (pick_idx == LastPort) ? '0 : pick_idx + 1'b1;

    always_comb begin
        fifo_rcn = '0;
        for (int i = 0; i < int'(PORTS); i++) begin
            if (gnt[i]) begin
                fifo_rcn = {1'b1, hold_d[i]};
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hold_v <= '0;
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < int'(PORTS); i++) begin
                if (cap[i]) begin
                    hold_v[i] <= 1'b1;
                end else if (gnt[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
            if (pick_any) begin
                rr_ptr <= rr_next;
            end
        end
    end

    // Payload needs no reset; hold_v qualifies it.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < int'(PORTS); i++) begin
            if (cap[i]) begin
                hold_d[i] <= req_rcn[RCN_W*i +: RCN_DATA_W];
            end
        end
    end

endmodule

// File: doc/rcn_fifo_push_arb.md
# rcn_fifo_push_arb

Round-robin arbiter that shares the push side of one rcn asynchronous transaction FIFO among several rcn requesters in the `clk_in` domain. Each requester gets a one-entry holding register. Every cycle the block grants one occupied holder whenever the FIFO is not full and drives the FIFO push port directly. It sits between local rcn masters and the clock-crossing FIFO, so several masters can reach a remote clock domain through one crossing.

## Interface
- `PORTS`, default 4: number of requesters; legal range 2..8.
- `clk_in`, input, 1: FIFO write-side clock; all logic runs on this clock.
- `rst_in`, input, 1: asynchronous, active-high reset.
- `req_rcn`, input, `PORTS*69`: requester transactions; slice i is `[69*i+68:69*i]`; bit 68 of each slice is valid.
- `req_busy`, output, `PORTS`: per-port backpressure; while high, requester i must hold its transaction stable.
- `fifo_rcn`, output, 69: FIFO write data; connects to the FIFO `rcn_in`.
- `fifo_push`, output, 1: FIFO push strobe.
- `fifo_full`, input, 1: FIFO `full` flag.
- `gnt_idx`, output, 3: index of the port granted this cycle; 0 when `fifo_push` is 0.

## Operation
- **Holding register per port.** Each port has `hold_v[i]` and `hold_d[i][67:0]`.
- **Capture.** At a clock edge, if `req_rcn[i][68]` is 1 and `req_busy[i]` is 0:
  - `hold_v[i]` is set to 1;
  - `hold_d[i]` is loaded from `req_rcn[i][67:0]`.
- **Busy.** `req_busy[i] = hold_v[i] & ~gnt[i]`, combinational. A port being drained this cycle accepts a new transaction at the same edge, so each port sustains one transaction per cycle when it is the only active port.
- **Arbitration.** Combinational: `gnt` is one-hot. It selects the first `i` with `hold_v[i]` = 1, scanning from `rr_ptr` upward modulo `PORTS`. `gnt` is all zero when `fifo_full` = 1 or no holder is valid.
- **Push.**
  - `fifo_push = |gnt`.
  - `fifo_rcn = {1'b1, hold_d[g]}` when pushing, else 69'd0.
  - `gnt_idx = g`, else 0.
- **Grant update.** At an edge where a grant occurs:
  - `hold_v[g]` is cleared, unless it is recaptured at that same edge;
  - `rr_ptr` becomes `(g+1) mod PORTS`.
- **Pointer hold.** `rr_ptr` is unchanged when no grant occurs.
- **Ordering.** Order within a port is preserved. Across ports the order is round-robin. No port waits more than `PORTS-1` grants once `fifo_full` is low.
- **Full FIFO.** When `fifo_full` = 1:
  - no push and no `rr_ptr` change;
  - holders keep their contents;
  - `req_busy` follows `hold_v`.
- **Invalid requests.** A request with bit 68 = 0 is never captured and never pushed.
- **Reset.** While `rst_in` is high:
  - `hold_v` = 0 and `rr_ptr` = 0;
  - `hold_d` is don't-care;
  - therefore `req_busy` = 0, `fifo_push` = 0, `fifo_rcn` = 0 and `gnt_idx` = 0.
- **Reset mid-operation.** Transactions in holders are discarded and not pushed.

## Timing
- **Latency.** A transaction captured at edge N is presented on `fifo_push` during cycle N+1 at the earliest, i.e. one cycle from input valid to push.
- **Why push is combinational.** `fifo_push` is combinational from registered `hold_v` and `rr_ptr` plus `fifo_full`. The FIFO registers `fifo_full` and updates it at the same edge as the push, so back-to-back pushes never overflow. The push path must not be registered, otherwise the full decision lags by one cycle.
- **Throughput.** One push per cycle aggregate while `fifo_full` = 0.
- **Combinational paths.** `fifo_full` → `gnt` → `req_busy`. Requesters must sample `req_busy` only at clock edges.

## Structure
- **Shared package `rcn_pkg`.**
  - `RCN_W` = 69.
  - `RCN_VALID` = 68.
  - `RCN_DATA_W` = 68.
  - Port-index width function (3 bits for `PORTS` ≤ 8).
- **Sub-module `rcn_rr_pick`.** Combinational round-robin picker.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant, index, any.
- **Top level.** Holds the holding registers, `rr_ptr` and the output mux.

## Test plan
- **Reset.** Assert `rst_in` with all ports presenting valid data → `req_busy` = 0, `fifo_push` = 0, `fifo_rcn` = 0; after release, the first grant goes to port 0.
- **Single port streaming.** Port 2 presents 20 back-to-back transactions with `fifo_full` = 0 → 20 pushes on consecutive cycles in order, `gnt_idx` = 2, `req_busy[2]` never high.
- **All ports contending.** All 4 ports continuously valid → `gnt_idx` sequence 0,1,2,3,0,… with no gaps; per-port payload order preserved.
- **Full backpressure.** Fill an attached 16-entry `rcn_fifo_async` with `clk_out` stopped → exactly 15 pushes, then `fifo_push` = 0 and `req_busy` = 1 on occupied ports. Restart `clk_out` and pop → traffic resumes with no loss or duplication.
- **Full toggling.** Toggle `fifo_full` every cycle with ports 1 and 3 valid → pushes only in non-full cycles, alternating 1,3; `rr_ptr` frozen during full cycles.
- **Reset mid-stream.** Assert `rst_in` with 3 holders occupied → no push of those entries after release; first new capture pushed one cycle later.
